// File: rtl/alu_multicycle_if.sv
// Operand-issue and result-consume handshakes of the multicycle ALU bundled as one interface.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
// Once raised, valid is held with stable payload until that transfer edge.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_X;
    logic [WIDTH-1:0] input_Y;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] output_Z;
    logic             flag_carry;
    logic             flag_ovf;
    logic             flag_zero;
    logic             div_by_zero;

    modport master (
        output in_valid, input_X, input_Y, opcode, out_ready,
        input  in_ready, out_valid, output_Z, flag_carry, flag_ovf, flag_zero, div_by_zero
    );

    modport slave (
        input  in_valid, input_X, input_Y, opcode, out_ready,
        output in_ready, out_valid, output_Z, flag_carry, flag_ovf, flag_zero, div_by_zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// Eight-op ALU with valid/ready on both sides; logic/ADD/SUB finish in one cycle,
// DIV/REM run an unsigned restoring divider producing one quotient bit per cycle.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    alu_multicycle_if.slave      bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_DIV  = 3'b111;

    localparam int          MSB      = WIDTH - 1;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             armed_q;
    logic             div_sel_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] z_q;
    logic             carry_q, ovf_q, zero_q, dbz_q;

    logic             accept;
    logic             is_divide;
    logic             y_is_zero;
    logic             div_last;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] res_z;
    logic             res_carry, res_ovf, res_dbz;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quot;
    logic [WIDTH-1:0] div_result;

    // armed_q keeps in_ready low until the first edge after reset release.
    assign bus.in_ready    = armed_q && (state_q == S_IDLE);
    assign accept          = bus.in_valid && bus.in_ready;
    assign is_divide       = (bus.opcode == OP_REM) || (bus.opcode == OP_DIV);
    assign y_is_zero       = (bus.input_Y == '0);
    assign div_last        = (cnt_q == CNT_LAST);

    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.output_Z    = z_q;
    assign bus.flag_carry  = carry_q;
    assign bus.flag_ovf    = ovf_q;
    assign bus.flag_zero   = zero_q;
    assign bus.div_by_zero = dbz_q;
    assign dbg_state       = state_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_divide && !y_is_zero) state_d = S_DIV;
                    else                         state_d = S_DONE;
                end
            end
            S_DIV: begin
                if (div_last) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    // Single-cycle results, computed straight from the operands presented at accept.
    always_comb begin
        sum_w     = {1'b0, bus.input_X} + {1'b0, bus.input_Y};
        diff_w    = bus.input_X - bus.input_Y;
        res_z     = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_dbz   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                res_z     = sum_w[WIDTH-1:0];
                res_carry = sum_w[WIDTH];
                res_ovf   = (bus.input_X[MSB] == bus.input_Y[MSB]) &&
                            (sum_w[MSB] != bus.input_X[MSB]);
            end
            OP_SUB: begin
                res_z     = diff_w;
                res_carry = (bus.input_X < bus.input_Y);
                res_ovf   = (bus.input_X[MSB] != bus.input_Y[MSB]) &&
                            (diff_w[MSB] != bus.input_X[MSB]);
            end
            OP_AND:  res_z = bus.input_X & bus.input_Y;
            OP_OR:   res_z = bus.input_X | bus.input_Y;
            OP_XOR:  res_z = bus.input_X ^ bus.input_Y;
            OP_XNOR: res_z = ~(bus.input_X ^ bus.input_Y);
            // Only reached with Y==0 as a result; nonzero divisors go through the divider.
            OP_REM: begin
                res_z   = bus.input_X;
                res_dbz = y_is_zero;
            end
            OP_DIV: begin
                res_z   = '1;
                res_dbz = y_is_zero;
            end
            default: res_z = '0;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder, trial-subtract.
    always_comb begin
        shifted = {rem_q, quot_q[MSB]};
        trial   = shifted - {1'b0, y_q};
        if (!trial[WIDTH]) begin
            step_rem  = trial[WIDTH-1:0];
            step_quot = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem  = shifted[WIDTH-1:0];
            step_quot = {quot_q[WIDTH-2:0], 1'b0};
        end
        div_result = div_sel_q ? step_quot : step_rem;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_sel_q <= 1'b0;
            y_q       <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            z_q       <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        div_sel_q <= bus.opcode[0];
                        y_q       <= bus.input_Y;
                        dbz_q     <= res_dbz;
                        if (is_divide && !y_is_zero) begin
                            rem_q  <= '0;
                            quot_q <= bus.input_X;
                            cnt_q  <= '0;
                        end else begin
                            z_q     <= res_z;
                            carry_q <= res_carry;
                            ovf_q   <= res_ovf;
                            zero_q  <= (res_z == '0);
                        end
                    end
                end
                S_DIV: begin
                    rem_q  <= step_rem;
                    quot_q <= step_quot;
                    cnt_q  <= cnt_q + WIDTH'(1);
                    if (div_last) begin
                        z_q     <= div_result;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        zero_q  <= (div_result == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: reset, every opcode, flag corners, divider latency,
// divide-by-zero, result backpressure and reset during a division.
module tb_alu_multicycle;

  localparam int W = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver: waits for in_ready, presents one op for one edge, then scrambles the inputs
  task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    bus.opcode   = op;
    bus.input_X  = x;
    bus.input_Y  = y;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.input_X  = $urandom;
    bus.input_Y  = $urandom;
    bus.opcode   = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " out_valid drop"}, bus.out_valid, 0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] ez, input logic ec,
                        input logic eo, input logic edz, input int elat);
    int lat;
    logic [W-1:0] e;
    exp_q.push_back(ez);
    issue(op, x, y);
    wait_result(lat);
    e = exp_q.pop_front();
    check({tag, " latency"}, lat, elat);
    check({tag, " Z"}, bus.output_Z, e);
    check({tag, " carry"}, bus.flag_carry, ec);
    check({tag, " ovf"}, bus.flag_ovf, eo);
    check({tag, " zero"}, bus.flag_zero, (e == '0));
    check({tag, " div_by_zero"}, bus.div_by_zero, edz);
    consume(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int lat;
    bus.in_valid  = 1'b1;
    bus.opcode    = 3'b000;
    bus.input_X   = 32'h1234_5678;
    bus.input_Y   = 32'h1111_1111;
    bus.out_ready = 1'b0;

    // reset held with in_valid high
    repeat (3) tick();
    check("rst in_ready", bus.in_ready, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst Z", bus.output_Z, 0);
    check("rst carry", bus.flag_carry, 0);
    check("rst ovf", bus.flag_ovf, 0);
    check("rst zero", bus.flag_zero, 0);
    check("rst dbz", bus.div_by_zero, 0);
    check("rst state", dbg_state, 0);
    reset = 1'b1;
    #1;
    check("release in_ready pre-edge", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    tick();
    check("release in_ready post-edge", bus.in_ready, 1);

    // single-cycle ops
    run_op("ADD", 3'b000, 32'hF535_87CA, 32'hF5A5_85AD, 32'hEADB_0D77, 1, 0, 0, 1);
    run_op("SUB", 3'b001, 32'hF535_87CA, 32'hF5A5_85AD, 32'hFF90_021D, 1, 0, 0, 1);
    run_op("AND", 3'b010, 32'hF535_87CA, 32'hF5A5_85AD, 32'hF525_8588, 0, 0, 0, 1);
    run_op("OR",  3'b011, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 0, 0, 0, 1);
    run_op("XOR", 3'b100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 0, 0, 0, 1);
    run_op("XNOR", 3'b101, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00FF_12CB, 0, 0, 0, 1);
    run_op("SUB ovf", 3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 0, 1);
    run_op("ADD wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0, 1);
    run_op("ADD ovf", 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0, 1);
    run_op("SUB eq", 3'b001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 0, 0, 0, 1);

    // divider
    run_op("DIV 100/7", 3'b111, 32'd100, 32'd7, 32'd14, 0, 0, 0, W + 1);
    run_op("REM 100/7", 3'b110, 32'd100, 32'd7, 32'd2, 0, 0, 0, W + 1);
    run_op("DIV x<y", 3'b111, 32'd3, 32'd10, 32'd0, 0, 0, 0, W + 1);
    run_op("REM x<y", 3'b110, 32'd3, 32'd10, 32'd3, 0, 0, 0, W + 1);
    run_op("DIV big", 3'b111, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 0, 0, 0, W + 1);
    run_op("REM big", 3'b110, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 0, 0, 0, W + 1);

    // divide by zero, then a normal op clears div_by_zero
    run_op("DIV by 0", 3'b111, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, 1, 1);
    run_op("REM by 0", 3'b110, 32'd5, 32'd0, 32'd5, 0, 0, 1, 1);
    run_op("ADD zero", 3'b000, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1);

    // backpressure: result held 10 cycles while a second op waits
    issue(3'b000, 32'd1, 32'd2);
    wait_result(lat);
    check("bp latency", lat, 1);
    bus.opcode   = 3'b001;
    bus.input_X  = 32'd9;
    bus.input_Y  = 32'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp Z held", bus.output_Z, 3);
      check("bp out_valid held", bus.out_valid, 1);
      check("bp in_ready low", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    consume("bp");
    check("bp Z after transfer", bus.output_Z, 3);
    check("bp state idle", dbg_state, 0);
    tick();
    check("bp no second result", bus.out_valid, 0);

    // reset during cycle 16 of a division
    issue(3'b111, 32'd100, 32'd7);
    check("mid-div state", dbg_state, 1);
    repeat (15) tick();
    #2;
    reset = 1'b0;
    #1;
    check("mid-div rst out_valid", bus.out_valid, 0);
    check("mid-div rst state", dbg_state, 0);
    check("mid-div rst in_ready", bus.in_ready, 0);
    tick();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("mid-div no result", seen, 0);
    check("mid-div idle", dbg_state, 0);
    check("mid-div in_ready", bus.in_ready, 1);
    run_op("ADD after abort", 3'b000, 32'd5, 32'd6, 32'd11, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
